ca_code_correlator: RTL

//  Downstream consumer of the C/A code generator: wipes the local code off baseband I/Q samples and

---
 rtl/gnss_pkg.sv | 17 +
 rtl/ca_sat_accum.sv | 85 ++++++++
 rtl/ca_code_correlator.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/gnss_pkg.sv
// -----------------------------------------------------------------------------
// gnss_pkg
//   Shared types and constants for the GNSS baseband blocks.
//   corr_state_e : correlator control state (IDLE / ARM / INTEG)
//   CA_CODE_LEN  : chips per C/A code period
// -----------------------------------------------------------------------------
package gnss_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      INTEG = 2'd2
   } corr_state_e;

   localparam int CA_CODE_LEN = 1023;

endpackage

// File: rtl/ca_sat_accum.sv
// -----------------------------------------------------------------------------
// ca_sat_accum
//   Signed saturating accumulator for one correlator arm (I or Q).
//   The sample is code-wiped here: neg=1 (chip=1) negates it before summing.
//
//   clk     in   system clock
//   rst     in   synchronous active-high reset (acc and ovf to 0)
//   clr     in   clear acc and ovf (highest priority after rst)
//   load    in   acc <= product (start of a new integration)
//   add     in   acc <= acc + product
//   neg     in   1 = negate the sample (code chip 1)
//   sample  in   signed sample, SAMPLE_W bits
//   acc     out  current accumulator value, ACC_W bits signed
//   ovf     out  sticky: a load/add clamped since the last clr
// -----------------------------------------------------------------------------
module ca_sat_accum #(
   parameter int SAMPLE_W = 4,
   parameter int ACC_W    = 24
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       load,
   input  logic                       add,
   input  logic                       neg,
   input  logic signed [SAMPLE_W-1:0] sample,
   output logic signed [ACC_W-1:0]    acc,
   output logic                       ovf
);

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    ovf_q, ovf_d;

   // One extra bit of headroom: the negated most-negative sample and any
   // single-step sum both fit, so saturation is detected from the top two bits.
   logic signed [ACC_W:0]   prod;
   logic signed [ACC_W:0]   base;
   logic signed [ACC_W:0]   sum;
   logic                    sat;
   logic signed [ACC_W-1:0] clamped;

   always_comb begin
      prod = {{(ACC_W + 1 - SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
      if (neg) begin
         prod = -prod;
      end
      base = load ? '0 : {acc_q[ACC_W-1], acc_q};
      sum  = base + prod;
      sat  = (sum[ACC_W] != sum[ACC_W-1]);
      if (sat) begin
         clamped = sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                              : {1'b0, {(ACC_W - 1){1'b1}}};
      end else begin
         clamped = sum[ACC_W-1:0];
      end
   end

   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (clr) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (load || add) begin
         acc_d = clamped;
         if (sat) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   assign acc = acc_q;
   assign ovf = ovf_q;

endmodule

// File: rtl/ca_code_correlator.sv
// -----------------------------------------------------------------------------
// ca_code_correlator
//   Wipes the local C/A code off baseband I/Q samples and coherently
//   integrates over n_epochs whole code periods, delimited by the code
//   generator's epoch flag. One I/Q pair is dumped per integration.
//   Code sign: chip=0 -> +1, chip=1 -> -1.
//
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   start         in   pulse: arm a new integration (aborts any in progress)
//   continuous    in   1 = re-arm gaplessly after every dump
//   n_epochs      in   code periods per integration, sampled on start (0 -> 1)
//   sample_valid  in   qualifies sample_i/sample_q/chip/epoch this cycle
//   sample_i/q    in   signed baseband samples
//   chip          in   local code chip aligned with the sample
//   epoch         in   sample is the first of a code period
//   acc_i/acc_q   out  last dumped correlation, held until the next dump
//   acc_valid     out  1-cycle pulse when acc_i/acc_q update
//   busy          out  state != IDLE
//   overflow      out  sticky saturation flag, cleared by start
//   dbg_state     out  current control state
//
//   Handshake: input side is valid-only (no ready). Every field is consumed
//   on each cycle sample_valid is high; with sample_valid low the inputs are
//   ignored and nothing changes. The output side is a one-cycle acc_valid
//   pulse with data held afterwards; there is no backpressure.
// -----------------------------------------------------------------------------
module ca_code_correlator
   import gnss_pkg::*;
#(
   parameter int SAMPLE_W = 4,
   parameter int ACC_W    = 24,
   parameter int NEP_W    = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       continuous,
   input  logic [NEP_W-1:0]           n_epochs,
   input  logic                       sample_valid,
   input  logic signed [SAMPLE_W-1:0] sample_i,
   input  logic signed [SAMPLE_W-1:0] sample_q,
   input  logic                       chip,
   input  logic                       epoch,
   output logic signed [ACC_W-1:0]    acc_i,
   output logic signed [ACC_W-1:0]    acc_q,
   output logic                       acc_valid,
   output logic                       busy,
   output logic                       overflow,
   output corr_state_e                dbg_state
);

   corr_state_e             state_q, state_d;
   logic [NEP_W-1:0]        n_lat_q, n_lat_d;
   logic [NEP_W-1:0]        cnt_q, cnt_d;
   logic [NEP_W-1:0]        cnt_inc;
   logic signed [ACC_W-1:0] dump_i_q, dump_i_d;
   logic signed [ACC_W-1:0] dump_q_q, dump_q_d;
   logic                    acc_valid_q, acc_valid_d;

   logic                    acc_clr;
   logic                    acc_load;
   logic                    acc_add;
   logic signed [ACC_W-1:0] sum_i;
   logic signed [ACC_W-1:0] sum_q;
   logic                    ovf_i;
   logic                    ovf_q;

   ca_sat_accum #(
      .SAMPLE_W (SAMPLE_W),
      .ACC_W    (ACC_W)
   ) u_accum_i (
      .clk    (clk),
      .rst    (rst),
      .clr    (acc_clr),
      .load   (acc_load),
      .add    (acc_add),
      .neg    (chip),
      .sample (sample_i),
      .acc    (sum_i),
      .ovf    (ovf_i)
   );

   ca_sat_accum #(
      .SAMPLE_W (SAMPLE_W),
      .ACC_W    (ACC_W)
   ) u_accum_q (
      .clk    (clk),
      .rst    (rst),
      .clr    (acc_clr),
      .load   (acc_load),
      .add    (acc_add),
      .neg    (chip),
      .sample (sample_q),
      .acc    (sum_q),
      .ovf    (ovf_q)
   );

   always_comb begin
      state_d     = state_q;
      n_lat_d     = n_lat_q;
      cnt_d       = cnt_q;
      dump_i_d    = dump_i_q;
      dump_q_d    = dump_q_q;
      acc_valid_d = 1'b0;
      acc_clr     = 1'b0;
      acc_load    = 1'b0;
      acc_add     = 1'b0;
      cnt_inc     = cnt_q + NEP_W'(1);

      if (start) begin
         // start wins over a same-cycle epoch; that epoch is not an alignment point
         n_lat_d = (n_epochs == '0) ? NEP_W'(1) : n_epochs;
         cnt_d   = '0;
         acc_clr = 1'b1;
         state_d = ARM;
      end else if (sample_valid) begin
         case (state_q)
            ARM: begin
               if (epoch) begin
                  acc_load = 1'b1;
                  cnt_d    = '0;
                  state_d  = INTEG;
               end
            end
            INTEG: begin
               if (!epoch) begin
                  acc_add = 1'b1;
               end else if (cnt_inc == n_lat_q) begin
                  // Dump the sums as they stand, before this epoch sample.
                  dump_i_d    = sum_i;
                  dump_q_d    = sum_q;
                  acc_valid_d = 1'b1;
                  if (continuous) begin
                     // This epoch sample opens the next integration.
                     acc_load = 1'b1;
                     cnt_d    = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  acc_add = 1'b1;
                  cnt_d   = cnt_inc;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         n_lat_q     <= '0;
         cnt_q       <= '0;
         dump_i_q    <= '0;
         dump_q_q    <= '0;
         acc_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_lat_q     <= n_lat_d;
         cnt_q       <= cnt_d;
         dump_i_q    <= dump_i_d;
         dump_q_q    <= dump_q_d;
         acc_valid_q <= acc_valid_d;
      end
   end

   assign acc_i     = dump_i_q;
   assign acc_q     = dump_q_q;
   assign acc_valid = acc_valid_q;
   assign busy      = (state_q != IDLE);
   assign overflow  = ovf_i | ovf_q;
   assign dbg_state = state_q;

endmodule
